// File: rtl/cache_mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
// The ARB_RR_EN macro (see arb_grant_sel) selects round-robin tie breaking.
package cache_mem_arb_pkg;

    // Default geometry: 16-byte lines addressed by block number
    localparam int unsigned DEF_ADDR_W = 28;
    localparam int unsigned DEF_DATA_W = 128;

    // Requester identifiers, also used as the stored last-grant value
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StDoneI,
        StDoneD
    } arb_state_e;

    typedef enum logic [1:0] {
        OpNone,
        OpRead,
        OpWrite
    } mem_op_e;

    // A requester raising both strobes is doing a dirty write-back; the
    // refill read follows as its own request, so write takes precedence.
    function automatic mem_op_e decode_op(input logic rd, input logic wr);
        if (wr) begin
            return OpWrite;
        end else if (rd) begin
            return OpRead;
        end
        return OpNone;
    endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner selection between the I-cache and D-cache requesters.
// Build option: define ARB_RR_EN for round-robin tie breaking; otherwise the
// D-cache wins every tie.
module arb_grant_sel
    import cache_mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

`ifndef ARB_RR_EN
    // Fixed priority does not look at history
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick the winner; a lone requester always wins
    always_comb begin
        grant_valid = req_i | req_d;
        grant       = GRANT_D;
        if (req_i && !req_d) begin
            grant = GRANT_I;
        end else if (req_i && req_d) begin
`ifdef ARB_RR_EN
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
            grant = GRANT_D;
`endif
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one external memory port between the I-cache and D-cache miss /
// write-back interfaces. One access at a time: grant in IDLE, hold the
// registered memory request in BUSY until mem_ready, then pulse the
// requester's ready for one cycle in DONE.
// Build option: ARB_RR_EN enables round-robin tie breaking (arb_grant_sel).
module cache_mem_arbiter
    import cache_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q;
    logic              last_grant_q;

    logic              req_i;
    logic              req_d;
    logic              grant_valid;
    logic              grant;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    mem_op_e           sel_op;

    assign req_i = i_mem_read | i_mem_write;
    assign req_d = d_mem_read | d_mem_write;

    arb_grant_sel u_grant_sel (
        .req_i       (req_i),
        .req_d       (req_d),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Route the winning requester's address, data and operation to the latch point
    always_comb begin
        sel_addr  = i_mem_addr;
        sel_wdata = i_mem_wdata;
        sel_op    = decode_op(i_mem_read, i_mem_write);
        if (grant == GRANT_D) begin
            sel_addr  = d_mem_addr;
            sel_wdata = d_mem_wdata;
            sel_op    = decode_op(d_mem_read, d_mem_write);
        end
    end

    // Arbiter FSM with registered memory-side and requester-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= GRANT_I;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_mem_rdata  <= '0;
            d_mem_rdata  <= '0;
            i_mem_ready  <= 1'b0;
            d_mem_ready  <= 1'b0;
        end else begin
            // Ready is a single-cycle pulse; only a completing BUSY raises it
            i_mem_ready <= 1'b0;
            d_mem_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // mem_ready here is stale or spurious and is ignored
                    if (grant_valid) begin
                        mem_addr     <= sel_addr;
                        mem_wdata    <= sel_wdata;
                        mem_write    <= (sel_op == OpWrite);
                        mem_read     <= (sel_op == OpRead);
                        last_grant_q <= grant;
                        state_q      <= (grant == GRANT_D) ? StBusyD : StBusyI;
                    end
                end
                StBusyI: begin
                    // The access completes even if the requester dropped its strobe
                    if (mem_ready) begin
                        i_mem_rdata <= mem_rdata;
                        i_mem_ready <= 1'b1;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        state_q     <= StDoneI;
                    end
                end
                StBusyD: begin
                    if (mem_ready) begin
                        d_mem_rdata <= mem_rdata;
                        d_mem_ready <= 1'b1;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        state_q     <= StDoneD;
                    end
                end
                // The requester sees ready this cycle and drops its request,
                // so returning to IDLE cannot re-grant the finished access.
                StDoneI, StDoneD: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Memory-side request must not move while waiting on memory
    property p_busy_hold;
        @(posedge clk) disable iff (!rst_n)
            (state_q inside {StBusyI, StBusyD}) && !mem_ready
            |=> $stable(mem_addr) && $stable(mem_wdata) && $stable(mem_write);
    endproperty
    a_busy_hold: assert property (p_busy_hold);

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_mem_ready && d_mem_ready));

    a_op_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_read && mem_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed stimulus pushes the
// expected memory accesses and ready responses; a monitor pops and compares.
module tb_cache_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;

    logic          clk;
    logic          rst_n;
    logic          i_mem_read, i_mem_write, i_mem_ready;
    logic [AW-1:0] i_mem_addr;
    logic [DW-1:0] i_mem_wdata, i_mem_rdata;
    logic          d_mem_read, d_mem_write, d_mem_ready;
    logic [AW-1:0] d_mem_addr;
    logic [DW-1:0] d_mem_wdata, d_mem_rdata;
    logic          mem_read, mem_write, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int total;
    int bad;
    int i_ready_cnt;
    int d_ready_cnt;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] rdata;
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];

    cache_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_read  (i_mem_read),
        .i_mem_write (i_mem_write),
        .i_mem_addr  (i_mem_addr),
        .i_mem_wdata (i_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_mem_rdata),
        .d_mem_ready (d_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic expect_acc(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        acc_t a;
        a.wr    = wr;
        a.addr  = addr;
        a.wdata = wdata;
        exp_acc.push_back(a);
    endtask

    task automatic issue(input logic is_d, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (is_d) begin
            d_mem_read  = rd;
            d_mem_write = wr;
            d_mem_addr  = addr;
            d_mem_wdata = wdata;
        end else begin
            i_mem_read  = rd;
            i_mem_write = wr;
            i_mem_addr  = addr;
            i_mem_wdata = wdata;
        end
    endtask

    task automatic drop(input logic is_d);
        if (is_d) begin
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
        end else begin
            i_mem_read  = 1'b0;
            i_mem_write = 1'b0;
        end
    endtask

    // Wait for an access on the memory port, answer after lat cycles, and
    // return on the negedge where the requester's ready must be high.
    task automatic serve(input int lat, input logic is_d, input logic [DW-1:0] rdata);
        rsp_t r;
        int   n;
        n = 0;
        while (!(mem_read || mem_write) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("serve_access_seen", 128'(mem_read | mem_write), 128'(1));
        repeat (lat) @(negedge clk);
        r.is_d  = is_d;
        r.rdata = rdata;
        exp_rsp.push_back(r);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
        check("ready_latency", 128'(is_d ? d_mem_ready : i_mem_ready), 128'(1));
    endtask

    task automatic check_rsp(input logic is_d, input logic [DW-1:0] rdata);
        rsp_t r;
        if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready got=requester%0d exp=none", is_d);
        end else begin
            r = exp_rsp.pop_front();
            check("rsp_requester", 128'(is_d), 128'(r.is_d));
            check("rsp_rdata", rdata, r.rdata);
        end
    endtask

    // Monitor: compares each new memory access and each ready pulse
    initial begin
        logic          active;
        acc_t          cur;
        logic [AW-1:0] held_addr;
        logic [DW-1:0] held_wdata;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else begin
                if (mem_read && mem_write) begin
                    total++;
                    bad++;
                    $display("FAIL op_exclusive got=rw exp=one");
                end
                if (mem_read || mem_write) begin
                    if (!active) begin
                        active     = 1'b1;
                        held_addr  = mem_addr;
                        held_wdata = mem_wdata;
                        if (exp_acc.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_access got=%0h exp=none", mem_addr);
                        end else begin
                            cur = exp_acc.pop_front();
                            check("acc_write", 128'(mem_write), 128'(cur.wr));
                            check("acc_read", 128'(mem_read), 128'(!cur.wr));
                            check("acc_addr", 128'(mem_addr), 128'(cur.addr));
                            check("acc_wdata", mem_wdata, cur.wdata);
                        end
                    end else begin
                        check("acc_addr_stable", 128'(mem_addr), 128'(held_addr));
                        check("acc_wdata_stable", mem_wdata, held_wdata);
                    end
                end else begin
                    active = 1'b0;
                end
                if (i_mem_ready && d_mem_ready) begin
                    total++;
                    bad++;
                    $display("FAIL ready_onehot got=both exp=one");
                end
                if (i_mem_ready) begin
                    i_ready_cnt++;
                    check_rsp(1'b0, i_mem_rdata);
                end
                if (d_mem_ready) begin
                    d_ready_cnt++;
                    check_rsp(1'b1, d_mem_rdata);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        logic [DW-1:0] last_i;
        logic [DW-1:0] last_d;
        logic [DW-1:0] rd_i;
        logic [DW-1:0] rd_d;
        int            cnt0;

        total = 0;
        bad = 0;
        i_ready_cnt = 0;
        d_ready_cnt = 0;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        issue(1'b0, 1'b0, 1'b0, '0, '0);
        issue(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_read", 128'(mem_read), 128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", mem_wdata, 128'(0));
        check("rst_i_ready", 128'(i_mem_ready), 128'(0));
        check("rst_d_ready", 128'(d_mem_ready), 128'(0));
        check("rst_i_rdata", i_mem_rdata, 128'(0));
        check("rst_d_rdata", d_mem_rdata, 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // I-cache read alone, with latency checks
        rd_i = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        expect_acc(1'b0, 28'h000_0010, '0);
        issue(1'b0, 1'b1, 1'b0, 28'h000_0010, '0);
        @(negedge clk);
        check("t2_mem_read_t1", 128'(mem_read), 128'(1));
        check("t2_mem_addr_t1", 128'(mem_addr), 128'(28'h000_0010));
        serve(3, 1'b0, rd_i);
        drop(1'b0);
        check("t2_mem_read_dropped", 128'(mem_read), 128'(0));
        last_i = rd_i;
        repeat (2) @(negedge clk);

        // Ties: D first then I, three rounds
        for (int k = 0; k < 3; k++) begin
            rd_d = 128'hD0D0_0000_0000_0000_0000_0000_0000_0000 + 128'(k);
            rd_i = 128'h1010_0000_0000_0000_0000_0000_0000_0000 + 128'(k);
            expect_acc(1'b0, 28'h100 + 28'(k), '0);
            expect_acc(1'b0, 28'h200 + 28'(k), '0);
            issue(1'b0, 1'b1, 1'b0, 28'h200 + 28'(k), '0);
            issue(1'b1, 1'b1, 1'b0, 28'h100 + 28'(k), '0);
            serve(2, 1'b1, rd_d);
            drop(1'b1);
            serve(1, 1'b0, rd_i);
            drop(1'b0);
            check("t3_d_rdata_hold", d_mem_rdata, rd_d);
            last_i = rd_i;
            repeat (2) @(negedge clk);
        end

        // D write-back (read+write both high) then refill
        cnt0 = d_ready_cnt;
        expect_acc(1'b1, 28'h000_000A, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
        expect_acc(1'b0, 28'h000_000B, '0);
        issue(1'b1, 1'b1, 1'b1, 28'h000_000A, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
        serve(2, 1'b1, 128'h5555);
        issue(1'b1, 1'b1, 1'b0, 28'h000_000B, '0);
        rd_d = 128'hB0B0_B0B0_0000_0000_0000_0000_0000_000B;
        serve(4, 1'b1, rd_d);
        drop(1'b1);
        last_d = rd_d;
        repeat (3) @(negedge clk);
        check("t5_two_d_ready", 128'(d_ready_cnt - cnt0), 128'(2));
        check("t5_i_rdata_hold", i_mem_rdata, last_i);

        // Spurious mem_ready while idle
        mem_ready = 1'b1;
        mem_rdata = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("t6_no_grant", 128'(mem_read | mem_write), 128'(0));
        check("t6_i_rdata_kept", i_mem_rdata, last_i);
        check("t6_d_rdata_kept", d_mem_rdata, last_d);

        // Request dropped mid-access still completes
        cnt0 = i_ready_cnt;
        rd_i = 128'h3333_0000_0000_0000_0000_0000_0000_0033;
        expect_acc(1'b0, 28'h000_0033, '0);
        issue(1'b0, 1'b1, 1'b0, 28'h000_0033, '0);
        @(negedge clk);
        drop(1'b0);
        serve(2, 1'b0, rd_i);
        last_i = rd_i;
        repeat (3) @(negedge clk);
        check("t6_drop_one_ready", 128'(i_ready_cnt - cnt0), 128'(1));

        // Asynchronous reset mid BUSY_D
        cnt0 = i_ready_cnt + d_ready_cnt;
        expect_acc(1'b0, 28'h000_0077, '0);
        issue(1'b1, 1'b1, 1'b0, 28'h000_0077, '0);
        repeat (2) @(negedge clk);
        check("t1_busy_before_rst", 128'(mem_read), 128'(1));
        rst_n = 1'b0;
        #1;
        check("t1_mem_read", 128'(mem_read), 128'(0));
        check("t1_mem_addr", 128'(mem_addr), 128'(0));
        check("t1_i_rdata", i_mem_rdata, 128'(0));
        check("t1_d_rdata", d_mem_rdata, 128'(0));
        drop(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t1_idle_after", 128'(mem_read | mem_write), 128'(0));
        check("t1_no_ready", 128'(i_ready_cnt + d_ready_cnt - cnt0), 128'(0));

`ifdef ARB_RR_EN
        // Continuous contention right after reset: D,I,D,I,D
        expect_acc(1'b0, 28'h400, '0);
        expect_acc(1'b0, 28'h500, '0);
        expect_acc(1'b0, 28'h401, '0);
        expect_acc(1'b0, 28'h501, '0);
        expect_acc(1'b0, 28'h402, '0);
        issue(1'b0, 1'b1, 1'b0, 28'h500, '0);
        issue(1'b1, 1'b1, 1'b0, 28'h400, '0);
        serve(1, 1'b1, 128'hD400);
        issue(1'b1, 1'b1, 1'b0, 28'h401, '0);
        serve(1, 1'b0, 128'hE500);
        issue(1'b0, 1'b1, 1'b0, 28'h501, '0);
        serve(1, 1'b1, 128'hD401);
        issue(1'b1, 1'b1, 1'b0, 28'h402, '0);
        serve(1, 1'b0, 128'hE501);
        drop(1'b0);
        serve(1, 1'b1, 128'hD402);
        drop(1'b1);
`else
        // Continuous contention with fixed priority: D keeps winning
        expect_acc(1'b0, 28'h400, '0);
        expect_acc(1'b0, 28'h401, '0);
        expect_acc(1'b0, 28'h500, '0);
        issue(1'b0, 1'b1, 1'b0, 28'h500, '0);
        issue(1'b1, 1'b1, 1'b0, 28'h400, '0);
        serve(1, 1'b1, 128'hD400);
        issue(1'b1, 1'b1, 1'b0, 28'h401, '0);
        serve(1, 1'b1, 128'hD401);
        drop(1'b1);
        serve(1, 1'b0, 128'hE500);
        drop(1'b0);
`endif
        repeat (4) @(negedge clk);
        check("acc_queue_drained", 128'(exp_acc.size()), 128'(0));
        check("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
